// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and defaults for the bit-serial subtractor
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - operand/result handshake bundle for serial_sub
interface serial_sub_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_c;
    logic [WIDTH-1:0] s_b;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_a;
    logic             m_borrow;

    modport slave (
        input  s_valid, s_c, s_b, m_ready,
        output s_ready, m_valid, m_a, m_borrow
    );

    modport master (
        output s_valid, s_c, s_b, m_ready,
        input  s_ready, m_valid, m_a, m_borrow
    );
endinterface

// File: rtl/serial_sub_fsub_bit.sv
// rtl/serial_sub_fsub_bit.sv - combinational 1-bit full subtractor (x - y - bin)
module fsub_bit (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = x_i ^ y_i ^ bin_i;
    assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial a = c - b (mod 2^WIDTH), LSB first; optional checks via SERIAL_SUB_XCHECK_EN
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_sub_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_sh_q, c_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] m_a_q, m_a_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             last_q, last_d;
    logic             m_borrow_q, m_borrow_d;
    logic             bit_d, bit_bout;

    fsub_bit u_fsub (
        .x_i    (c_sh_q[0]),
        .y_i    (b_sh_q[0]),
        .bin_i  (br_q),
        .d_o    (bit_d),
        .bout_o (bit_bout)
    );

    assign bus.s_ready  = (state_q == IDLE);
    assign bus.m_valid  = (state_q == DONE);
    assign bus.m_a      = m_a_q;
    assign bus.m_borrow = m_borrow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            c_sh_q     <= '0;
            b_sh_q     <= '0;
            res_q      <= '0;
            m_a_q      <= '0;
            cnt_q      <= '0;
            br_q       <= 1'b0;
            last_q     <= 1'b0;
            m_borrow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_sh_q     <= c_sh_d;
            b_sh_q     <= b_sh_d;
            res_q      <= res_d;
            m_a_q      <= m_a_d;
            cnt_q      <= cnt_d;
            br_q       <= br_d;
            last_q     <= last_d;
            m_borrow_q <= m_borrow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        c_sh_d     = c_sh_q;
        b_sh_d     = b_sh_q;
        res_d      = res_q;
        m_a_d      = m_a_q;
        cnt_d      = cnt_q;
        br_d       = br_q;
        last_d     = last_q;
        m_borrow_d = m_borrow_q;

        case (state_q)
            IDLE: begin
                if (bus.s_valid) begin
                    state_d = CALC;
                    c_sh_d  = bus.s_c;
                    b_sh_d  = bus.s_b;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    last_d  = 1'b0;
                end
            end
            CALC: begin
                // WIDTH bit-cycles, then one cycle to publish the result registers
                if (!last_q) begin
                    c_sh_d = c_sh_q >> 1;
                    b_sh_d = b_sh_q >> 1;
                    res_d  = {bit_d, res_q[WIDTH-1:1]};
                    br_d   = bit_bout;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = DONE;
                    m_a_d      = res_q;
                    m_borrow_d = br_q;
                end
            end
            DONE: begin
                if (bus.m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SERIAL_SUB_XCHECK_EN
    logic [WIDTH-1:0] c_chk_q;
    logic [WIDTH-1:0] b_chk_q;

    always_ff @(posedge clk) begin
        if (rst_n && state_q == IDLE && bus.s_valid) begin
            if ($isunknown({bus.s_c, bus.s_b})) begin
                $error("XCHK");
            end
            c_chk_q <= bus.s_c;
            b_chk_q <= bus.s_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && state_q == DONE && bus.m_ready) begin
            if (WIDTH'(m_a_q + b_chk_q) !== c_chk_q) begin
                $error("BAD");
            end
        end
    end
`else
    // checks compiled out
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - directed and randomized self-checking bench for serial_sub
module tb_serial_sub;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_sub_if #(.WIDTH(8)) bus ();

    serial_sub #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for IDLE, presents one operand pair, returns clocks from accept edge to m_valid.
    task automatic do_op(input logic [7:0] c, input logic [7:0] b, output int lat);
        int w;
        w = 0;
        while (bus.s_ready !== 1'b1 && w < 100) begin
            step();
            w++;
        end
        chk("idle_wait", {31'd0, bus.s_ready}, 32'd1);
        bus.s_c     = c;
        bus.s_b     = b;
        bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        lat = 0;
        while (bus.m_valid !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          spurious;
        int          sent;
        int          got;
        int          cyc;
        logic [7:0]  cur_c, cur_b;
        logic [7:0]  exp_a;
        logic        exp_br;
        logic [15:0] ent;
        logic [15:0] q[$];

        checks   = 0;
        failures = 0;
        bus.s_valid = 1'b0;
        bus.s_c     = '0;
        bus.s_b     = '0;
        bus.m_ready = 1'b1;

        // 1: reset with s_valid asserted
        rst_n       = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_c     = 8'd3;
        bus.s_b     = 8'd2;
        repeat (3) step();
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_m_a", {24'd0, bus.m_a}, 32'd0);
        chk("rst_m_borrow", {31'd0, bus.m_borrow}, 32'd0);
        bus.s_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        chk("rst_no_op", {31'd0, bus.m_valid}, 32'd0);

        // 2: basic op and latency
        do_op(8'd3, 8'd2, lat);
        chk("lat_3m2", lat, 32'd9);
        chk("a_3m2", {24'd0, bus.m_a}, 32'd1);
        chk("br_3m2", {31'd0, bus.m_borrow}, 32'd0);
        step();
        chk("handshake_clear", {31'd0, bus.m_valid}, 32'd0);
        chk("ready_after_hs", {31'd0, bus.s_ready}, 32'd1);

        // 3: wrap and equal operands
        do_op(8'd2, 8'd5, lat);
        chk("a_2m5", {24'd0, bus.m_a}, 32'hFD);
        chk("br_2m5", {31'd0, bus.m_borrow}, 32'd1);
        step();
        do_op(8'hFF, 8'hFF, lat);
        chk("a_ffmff", {24'd0, bus.m_a}, 32'd0);
        chk("br_ffmff", {31'd0, bus.m_borrow}, 32'd0);
        step();

        // 4: backpressure with a competing request
        bus.m_ready = 1'b0;
        do_op(8'd7, 8'd1, lat);
        bus.s_valid = 1'b1;
        bus.s_c     = 8'h55;
        bus.s_b     = 8'h11;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_m_valid", {31'd0, bus.m_valid}, 32'd1);
            chk("bp_m_a", {24'd0, bus.m_a}, 32'd6);
            chk("bp_s_ready", {31'd0, bus.s_ready}, 32'd0);
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        step();
        chk("bp_release", {31'd0, bus.m_valid}, 32'd0);
        chk("bp_idle", {31'd0, bus.s_ready}, 32'd1);

        // 5: reset during CALC aborts the op
        bus.s_c     = 8'd9;
        bus.s_b     = 8'd4;
        bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("abort_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("abort_m_a", {24'd0, bus.m_a}, 32'd0);
        chk("abort_s_ready", {31'd0, bus.s_ready}, 32'd1);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.m_valid !== 1'b0) spurious++;
        end
        chk("abort_no_result", spurious, 32'd0);
        do_op(8'd5, 8'd5, lat);
        chk("lat_5m5", lat, 32'd9);
        chk("a_5m5", {24'd0, bus.m_a}, 32'd0);
        chk("br_5m5", {31'd0, bus.m_borrow}, 32'd0);
        step();

        // 6: random back-to-back traffic against an arithmetic model
        sent  = 0;
        got   = 0;
        cyc   = 0;
        cur_c = 8'($urandom);
        cur_b = 8'($urandom);
        while (got < 1000 && cyc < 60000) begin
            bus.m_ready = ($urandom_range(0, 3) != 0);
            bus.s_c     = cur_c;
            bus.s_b     = cur_b;
            bus.s_valid = (sent < 1000);
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                chk("rand_q_nonempty", (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (q.size() > 0) begin
                    ent    = q.pop_front();
                    exp_a  = ent[15:8] - ent[7:0];
                    exp_br = (ent[15:8] < ent[7:0]);
                    chk("rand_a", {24'd0, bus.m_a}, {24'd0, exp_a});
                    chk("rand_br", {31'd0, bus.m_borrow}, {31'd0, exp_br});
                end
                got++;
            end
            if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) begin
                q.push_back({cur_c, cur_b});
                sent++;
                cur_c = 8'($urandom);
                cur_b = 8'($urandom);
            end
            step();
            cyc++;
        end
        bus.s_valid = 1'b0;
        chk("rand_all_results", got, 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
